// File: rtl/dmem_responder.sv
// Word-organised data-memory responder with req/ack handshake, programmable wait states,
// and rejection of illegal byte-lane masks and out-of-range word indices.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  we,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  output logic [31:0] drdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned WADR_W = 30;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [WADR_W-1:0]   addr_q, addr_n;
  logic [3:0]          we_q, we_n;
  logic [31:0]         wdata_q, wdata_n;
  logic [31:0]         drdata_n;
  logic                ack_n, err_n, busy_n;

  logic [31:0]         mem [DEPTH_WORDS];
  logic [IDX_W-1:0]    idx;
  logic                in_range, mask_ok, reject, ram_we;
  logic [31:0]         old_word, new_word;

  // Byte-offset bits never select anything: accesses are whole-word.
  logic                unused_bits;
  assign unused_bits = ^daddr[1:0];

  assign idx      = addr_q[IDX_W-1:0];
  assign in_range = {2'b00, addr_q} < 32'(DEPTH_WORDS);
  assign reject   = !in_range || !mask_ok;

  // Legal masks: read, single byte, aligned halfword, full word.
  always_comb begin
    mask_ok = 1'b0;
    case (we_q)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: mask_ok = 1'b1;
      default:                   mask_ok = 1'b0;
    endcase
  end

  // Post-write word: untouched lanes keep the stored bytes.
  always_comb begin
    old_word = in_range ? mem[idx] : 32'h0;
    new_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (we_q[i]) new_word[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    addr_n   = addr_q;
    we_n     = we_q;
    wdata_n  = wdata_q;
    drdata_n = drdata;
    ack_n    = 1'b0;
    err_n    = 1'b0;
    ram_we   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          addr_n  = daddr[31:2];
          we_n    = we;
          wdata_n = dwdata;
          cnt_n   = CNT_W'(WAIT_CYCLES);
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else begin
          state_n  = S_RESP;
          ack_n    = 1'b1;
          err_n    = reject;
          ram_we   = !reject && (we_q != 4'b0000);
          drdata_n = reject ? 32'h0 : new_word;
        end
      end
      S_RESP: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      we_q    <= '0;
      wdata_q <= '0;
      drdata  <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      addr_q  <= addr_n;
      we_q    <= we_n;
      wdata_q <= wdata_n;
      drdata  <= drdata_n;
      ack     <= ack_n;
      err     <= err_n;
      busy    <= busy_n;
    end
  end

  // RAM contents survive reset; writes only happen on the WAIT->RESP edge.
  always_ff @(posedge clk) begin
    if (ram_we) mem[idx] <= new_word;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with WAIT_CYCLES=2, one with WAIT_CYCLES=0.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req, sel;
  logic [3:0]  we;
  logic [31:0] daddr, dwdata;
  logic        req2, req0;
  logic [31:0] drdata2, drdata0, drdata_s;
  logic        ack2, ack0, err2, err0, busy2, busy0;
  logic        ack_s, err_s, busy_s;

  assign req2     = req & ~sel;
  assign req0     = req & sel;
  assign drdata_s = sel ? drdata0 : drdata2;
  assign ack_s    = sel ? ack0 : ack2;
  assign err_s    = sel ? err0 : err2;
  assign busy_s   = sel ? busy0 : busy2;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req(req2), .we(we), .daddr(daddr), .dwdata(dwdata),
    .drdata(drdata2), .ack(ack2), .err(err2), .busy(busy2)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we), .daddr(daddr), .dwdata(dwdata),
    .drdata(drdata0), .ack(ack0), .err(err0), .busy(busy0)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push_exp(input logic [31:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    sb.push_back(x);
  endtask

  // One transaction on the selected instance: capture, latency, response, one-cycle ack.
  task automatic do_txn(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                        input logic [31:0] exp_d, input logic exp_e, input string name);
    exp_t x;
    int   n;
    int   lat;
    lat = sel ? 1 : 3;
    @(negedge clk);
    daddr = a; we = m; dwdata = d; req = 1'b1;
    push_exp(exp_d, exp_e);
    @(posedge clk); #1;
    req = 1'b0; daddr = 32'hFFFF_FFFC; we = 4'b0101; dwdata = 32'hA5A5_A5A5;
    checks++;
    if (busy_s !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_capture got %b want 1", name, busy_s);
    end
    n = 0;
    while (ack_s !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    x = '0;
    if (sb.size() > 0) x = sb.pop_front();
    checks++;
    if (ack_s !== 1'b1) begin
      errors++; $display("FAIL %s ack_timeout got no ack want ack after %0d edges", name, lat);
    end else if (n !== lat) begin
      errors++; $display("FAIL %s latency got %0d want %0d", name, n, lat);
    end
    checks++;
    if (drdata_s !== x.data || err_s !== x.err) begin
      errors++; $display("FAIL %s response got drdata=%h err=%b want drdata=%h err=%b",
                         name, drdata_s, err_s, x.data, x.err);
    end
    @(posedge clk); #1;
    checks++;
    if (ack_s !== 1'b0 || err_s !== 1'b0 || busy_s !== 1'b0 || drdata_s !== x.data) begin
      errors++; $display("FAIL %s after_ack got ack=%b err=%b busy=%b drdata=%h want 0 0 0 %h",
                         name, ack_s, err_s, busy_s, drdata_s, x.data);
    end
  endtask

  task automatic test_reset();
    exp_t x;
    int   n;
    sel = 1'b0; reset = 1'b0; req = 1'b1;
    daddr = 32'h10; we = 4'b1111; dwdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ack2 !== 1'b0 || err2 !== 1'b0 || busy2 !== 1'b0 || drdata2 !== 32'h0) begin
        errors++; $display("FAIL reset_hold got ack=%b err=%b busy=%b drdata=%h want 0 0 0 0",
                           ack2, err2, busy2, drdata2);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    push_exp(32'hDEAD_BEEF, 1'b0);
    @(posedge clk); #1;
    req = 1'b0;
    checks++;
    if (busy2 !== 1'b1) begin
      errors++; $display("FAIL reset_first_capture busy got %b want 1", busy2);
    end
    n = 0;
    while (ack2 !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    x = '0;
    if (sb.size() > 0) x = sb.pop_front();
    checks++;
    if (ack2 !== 1'b1 || n !== 3) begin
      errors++; $display("FAIL reset_write_latency got ack=%b after %0d edges want ack after 3", ack2, n);
    end
    checks++;
    if (drdata2 !== x.data || err2 !== x.err) begin
      errors++; $display("FAIL reset_write_echo got drdata=%h err=%b want %h %b",
                         drdata2, err2, x.data, x.err);
    end
    @(posedge clk); #1;
    checks++;
    if (ack2 !== 1'b0) begin
      errors++; $display("FAIL reset_write_ack_width got ack=%b want 0", ack2);
    end
  endtask

  task automatic test_full_word();
    sel = 1'b0;
    do_txn(32'h10, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b0, "full_read");
  endtask

  task automatic test_byte_lane();
    sel = 1'b0;
    do_txn(32'h10, 4'b0100, 32'h00AA_0000, 32'hDEAA_BEEF, 1'b0, "lane2_write");
    do_txn(32'h12, 4'b0000, 32'h0,         32'hDEAA_BEEF, 1'b0, "lane2_read");
  endtask

  task automatic test_errors();
    sel = 1'b0;
    do_txn(32'h10,   4'b0101, 32'hFFFF_FFFF, 32'h0,         1'b1, "bad_mask_0101");
    do_txn(32'h10,   4'b0110, 32'hFFFF_FFFF, 32'h0,         1'b1, "bad_mask_0110");
    do_txn(32'h10,   4'b0000, 32'h0,         32'hDEAA_BEEF, 1'b0, "read_after_bad");
    do_txn(32'h1000, 4'b0000, 32'h0,         32'h0,         1'b1, "read_out_of_range");
    do_txn(32'h1000, 4'b1111, 32'h1111_1111, 32'h0,         1'b1, "write_out_of_range");
    do_txn(32'h0FFC, 4'b1111, 32'h0123_4567, 32'h0123_4567, 1'b0, "write_last_word");
    do_txn(32'h0FFC, 4'b1100, 32'hABCD_0000, 32'hABCD_4567, 1'b0, "half_write_last");
    do_txn(32'h0FFF, 4'b0000, 32'h0,         32'hABCD_4567, 1'b0, "read_last_word");
  endtask

  task automatic test_back_to_back();
    exp_t x;
    int   acks, lows, last, k;
    sel = 1'b1;
    do_txn(32'h10, 4'b1111, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, "b2b_preload");
    @(negedge clk);
    daddr = 32'h10; we = 4'b0000; dwdata = 32'h0; req = 1'b1;
    for (int i = 0; i < 3; i++) push_exp(32'hCAFE_F00D, 1'b0);
    acks = 0; lows = 0; last = 0; k = 0;
    while (acks < 3 && k < 30) begin
      @(posedge clk); #1; k++;
      if (ack0 === 1'b1) begin
        x = '0;
        if (sb.size() > 0) x = sb.pop_front();
        checks++;
        if (acks == 0 && k !== 2) begin
          errors++; $display("FAIL b2b_first_latency got edge %0d want 2", k);
        end else if (acks > 0 && (k - last !== 3 || lows !== 1)) begin
          errors++; $display("FAIL b2b_spacing got gap=%0d busy_low=%0d want gap=3 busy_low=1",
                             k - last, lows);
        end
        checks++;
        if (drdata0 !== x.data || err0 !== x.err) begin
          errors++; $display("FAIL b2b_data got drdata=%h err=%b want %h %b",
                             drdata0, err0, x.data, x.err);
        end
        last = k; lows = 0; acks++;
        if (acks == 3) req = 1'b0;
      end else if (busy0 === 1'b0) begin
        lows++;
      end
    end
    checks++;
    if (acks !== 3) begin
      errors++; $display("FAIL b2b_ack_count got %0d want 3", acks);
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy0 !== 1'b0 || ack0 !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got busy=%b ack=%b want 0 0", busy0, ack0);
    end
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    sel = 1'b0;
    do_txn(32'h20, 4'b1111, 32'h55AA_55AA, 32'h55AA_55AA, 1'b0, "mid_wait_preload");
    @(negedge clk);
    daddr = 32'h20; we = 4'b1111; dwdata = 32'h1234_5678; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if (busy2 !== 1'b0 || drdata2 !== 32'h0 || ack2 !== 1'b0) begin
      errors++; $display("FAIL mid_wait_async got busy=%b drdata=%h ack=%b want 0 0 0",
                         busy2, drdata2, ack2);
    end
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack2 === 1'b1 || busy2 === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL mid_wait_no_ack got %0d active cycles want 0", seen);
    end
    do_txn(32'h20, 4'b0000, 32'h0, 32'h55AA_55AA, 1'b0, "mid_wait_read");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    sel = 1'b0; reset = 1'b0; req = 1'b0;
    we = 4'b0000; daddr = 32'h0; dwdata = 32'h0;
    test_reset();
    test_full_word();
    test_byte_lane();
    test_errors();
    test_back_to_back();
    test_reset_mid_wait();
    checks++;
    if (sb.size() !== 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
